// File: rtl/uart_frame_rx_pkg.sv
// uart_frame_rx_pkg: sync byte, one-hot state encodings and error codes shared
// by the UART deframer and the downstream command decoder.
package uart_frame_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [4:0] {
    ST_HUNT    = 5'b00001,
    ST_LEN     = 5'b00010,
    ST_PAYLOAD = 5'b00100,
    ST_CHECK   = 5'b01000,
    ST_SEND    = 5'b10000
  } state_t;

  localparam logic [1:0] ERR_BAD_LEN  = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  // A zero length or one that cannot fit the payload buffer rejects the frame.
  function automatic logic len_invalid(input logic [7:0] len_byte,
                                       input logic [7:0] max_len);
    return (len_byte == 8'h00) || (len_byte > max_len);
  endfunction

endpackage

// File: rtl/uart_frame_rx_frame_buf.sv
// frame_buf: payload store for the deframer, simple dual-port with synchronous
// write and an enabled, resettable registered read port.
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the deframer's byte output, so it holds
  // whenever no read is issued and clears on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: sync-hunting, length-prefixed deframer that replays payloads
// on a valid/ready stream. Define UART_FRAME_CHECKSUM_EN to expect a CHK byte.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CLOCKS = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_last_o,
  input  logic       byte_ready_i,
  output logic       frame_ok_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CLOCKS);
  localparam logic [7:0]    MAX_LEN_B    = 8'(MAX_LEN);

  state_t        state;
  logic [7:0]    len;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          rd_done;
  logic [TW-1:0] timer;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  logic wr_en;
  logic rd_en;
  logic send_adv;
  logic last_wr;
  logic last_rd;
  logic timer_active;
  logic timeout_hit;

  // The output slot can take a new byte when empty or when its byte transfers;
  // every such cycle reads the next entry ahead so replay has no bubbles.
  assign send_adv     = !byte_valid_o || byte_ready_i;
  assign wr_en        = (state == ST_PAYLOAD) && valid_i;
  assign rd_en        = (state == ST_SEND) && send_adv && !rd_done;
  assign last_wr      = (8'(wr_idx) == len - 8'd1);
  assign last_rd      = (8'(rd_idx) == len - 8'd1);
  assign timer_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign timeout_hit  = timer_active && !valid_i && (timer == TW'(1));

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_frame_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (byte_o)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_HUNT;
      len          <= 8'h00;
      wr_idx       <= '0;
      rd_idx       <= '0;
      rd_done      <= 1'b0;
      timer        <= TIMEOUT_LOAD;
`ifdef UART_FRAME_CHECKSUM_EN
      sum          <= 8'h00;
`endif
      byte_valid_o <= 1'b0;
      byte_last_o  <= 1'b0;
      frame_ok_o   <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= ERR_BAD_LEN;
    end else begin
      frame_ok_o <= 1'b0;
      err_o      <= 1'b0;

      // An arriving byte always reloads, so it wins over a same-cycle expiry.
      if (valid_i) begin
        timer <= TIMEOUT_LOAD;
      end else if (timer_active) begin
        timer <= timer - TW'(1);
      end

      if (timeout_hit) begin
        state      <= ST_HUNT;
        err_o      <= 1'b1;
        err_code_o <= ERR_TIMEOUT;
      end else begin
        unique case (state)
          ST_HUNT: begin
            if (valid_i && (data_i == SYNC_BYTE)) begin
              state <= ST_LEN;
            end
          end

          ST_LEN: begin
            if (valid_i) begin
              if (len_invalid(data_i, MAX_LEN_B)) begin
                state      <= ST_HUNT;
                err_o      <= 1'b1;
                err_code_o <= ERR_BAD_LEN;
              end else begin
                len    <= data_i;
                wr_idx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                sum    <= data_i;
`endif
                state  <= ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            if (valid_i) begin
              wr_idx <= wr_idx + IW'(1);
`ifdef UART_FRAME_CHECKSUM_EN
              sum    <= sum + data_i;
              if (last_wr) begin
                state <= ST_CHECK;
              end
`else
              if (last_wr) begin
                state      <= ST_SEND;
                frame_ok_o <= 1'b1;
                rd_idx     <= '0;
                rd_done    <= 1'b0;
              end
`endif
            end
          end

          ST_CHECK: begin
`ifdef UART_FRAME_CHECKSUM_EN
            if (valid_i) begin
              if (8'(sum + data_i) == 8'h00) begin
                state      <= ST_SEND;
                frame_ok_o <= 1'b1;
                rd_idx     <= '0;
                rd_done    <= 1'b0;
              end else begin
                state      <= ST_HUNT;
                err_o      <= 1'b1;
                err_code_o <= ERR_CHECKSUM;
              end
            end
`else
            state <= ST_HUNT;
`endif
          end

          ST_SEND: begin
            // Bytes cannot be back-pressured upstream, so they are dropped.
            if (valid_i) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_OVERRUN;
            end
            if (send_adv) begin
              if (!rd_done) begin
                byte_valid_o <= 1'b1;
                byte_last_o  <= last_rd;
                if (last_rd) begin
                  rd_done <= 1'b1;
                end else begin
                  rd_idx <= rd_idx + IW'(1);
                end
              end else begin
                byte_valid_o <= 1'b0;
                byte_last_o  <= 1'b0;
                state        <= ST_HUNT;
              end
            end
          end

          default: begin
            state <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed scoreboard bench for uart_frame_rx; follows the
// DUT's UART_FRAME_CHECKSUM_EN setting when building frames.
module tb_uart_frame_rx;

  localparam int MAXL = 16;
  localparam int TO   = 1000;

  typedef struct packed {
    logic [7:0] data;
    logic       is_last;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_last_o;
  logic       byte_ready_i;
  logic       frame_ok_o;
  logic       err_o;
  logic [1:0] err_code_o;

  uart_frame_rx #(
    .MAX_LEN        (MAXL),
    .TIMEOUT_CLOCKS (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_last_o  (byte_last_o),
    .byte_ready_i (byte_ready_i),
    .frame_ok_o   (frame_ok_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobe_cyc = 0;
  int   ok_count = 0;
  int   ok_cyc = -1;
  int   err_count = 0;
  int   err_cyc = -1;
  int   xfer_count = 0;
  int   last_xfer_cyc = -1;
  int   first_valid_cyc = -1;
  exp_t exp_q [$];
  logic [1:0] err_q [$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_last = 1'b0;
  logic       prev_xfer_last = 1'b0;
  exp_t       mon_e;
  logic [1:0] mon_code;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    data_i     = b;
    valid_i    = 1'b1;
    strobe_cyc = cyc;
    @(posedge clock);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sends sync, LEN, payload (LSB byte first) and, in checksum builds, a good CHK.
  task automatic applyStimulus(input int n, input logic [63:0] payload, input bit expect_ok);
    logic [7:0] b;
    logic [7:0] s;
    strobe(8'hA5);
    strobe(8'(n));
    s = 8'(n);
    for (int i = 0; i < n; i++) begin
      b = payload[8*i +: 8];
      s = s + b;
      if (expect_ok) exp_q.push_back('{data: b, is_last: (i == n - 1)});
      strobe(b);
    end
`ifdef UART_FRAME_CHECKSUM_EN
    strobe(8'h00 - s);
`endif
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_byte_valid"}, 32'(byte_valid_o), 32'd0);
    checkOutput({tag, "_byte_last"}, 32'(byte_last_o), 32'd0);
    checkOutput({tag, "_byte"}, 32'(byte_o), 32'd0);
    checkOutput({tag, "_frame_ok"}, 32'(frame_ok_o), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_o), 32'd0);
    checkOutput({tag, "_err_code"}, 32'(err_code_o), 32'd0);
  endtask

  // Output monitor: scoreboard pops, stall stability and event timestamps.
  always @(negedge clock) begin
    if (reset) begin
      prev_valid     = 1'b0;
      prev_xfer_last = 1'b0;
    end else begin
      if (prev_xfer_last) checkOutput("valid_drop", 32'(byte_valid_o), 32'd0);
      if (prev_valid && !prev_ready) begin
        checkOutput("stall_valid", 32'(byte_valid_o), 32'd1);
        checkOutput("stall_byte", 32'(byte_o), 32'(prev_byte));
        checkOutput("stall_last", 32'(byte_last_o), 32'(prev_last));
      end
      prev_xfer_last = 1'b0;
      if (byte_valid_o && byte_ready_i) begin
        checkOutput("byte_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("byte_data", 32'(byte_o), 32'(mon_e.data));
          checkOutput("byte_last", 32'(byte_last_o), 32'(mon_e.is_last));
        end
        xfer_count++;
        prev_xfer_last = byte_last_o;
        if (byte_last_o) last_xfer_cyc = cyc;
      end
      if (byte_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_ok_o) begin
        ok_count++;
        ok_cyc = cyc;
      end
      if (err_o) begin
        checkOutput("err_pending", 32'(err_q.size() != 0), 32'd1);
        if (err_q.size() != 0) begin
          mon_code = err_q.pop_front();
          checkOutput("err_code", 32'(err_code_o), 32'(mon_code));
        end
        err_count++;
        err_cyc = cyc;
      end
      prev_valid = byte_valid_o;
      prev_ready = byte_ready_i;
      prev_byte  = byte_o;
      prev_last  = byte_last_o;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    int t2;
    int n;
    int e_base;
    int o_base;
    int x_base;

    reset        = 1'b1;
    valid_i      = 1'b0;
    data_i       = 8'h00;
    byte_ready_i = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkResetState("por");
    reset = 1'b0;
    idle(2);

    $display("[TB] good frame 11 22 33, ready high");
    first_valid_cyc = -1;
    applyStimulus(3, 64'h33_22_11, 1'b1);
    t = strobe_cyc;
    waitDrain(50);
    checkOutput("ok_cycle", 32'(ok_cyc), 32'(t + 1));
    checkOutput("first_valid_cycle", 32'(first_valid_cyc), 32'(t + 2));
    checkOutput("last_xfer_cycle", 32'(last_xfer_cyc), 32'(t + 4));
    checkOutput("ok_count", 32'(ok_count), 32'd1);

`ifdef UART_FRAME_CHECKSUM_EN
    $display("[TB] bad checksum then good frame");
    e_base = err_count;
    o_base = ok_count;
    x_base = xfer_count;
    strobe(8'hA5);
    strobe(8'h03);
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    err_q.push_back(2'd1);
    strobe(8'h98);
    t = strobe_cyc;
    idle(4);
    checkOutput("chk_err_count", 32'(err_count), 32'(e_base + 1));
    checkOutput("chk_err_cycle", 32'(err_cyc), 32'(t + 1));
    checkOutput("chk_no_bytes", 32'(xfer_count), 32'(x_base));
    checkOutput("chk_no_ok", 32'(ok_count), 32'(o_base));
    applyStimulus(2, 64'hBB_AA, 1'b1);
    waitDrain(50);
    checkOutput("after_chk_ok", 32'(ok_count), 32'(o_base + 1));
`endif

    $display("[TB] bad lengths 00 and 11");
    e_base = err_count;
    err_q.push_back(2'd0);
    strobe(8'hA5);
    strobe(8'h00);
    err_q.push_back(2'd0);
    strobe(8'hA5);
    strobe(8'h11);
    t2 = strobe_cyc;
    idle(3);
    checkOutput("badlen_count", 32'(err_count), 32'(e_base + 2));
    checkOutput("badlen_cycle", 32'(err_cyc), 32'(t2 + 1));

    $display("[TB] junk before sync");
    e_base = err_count;
    o_base = ok_count;
    strobe(8'h00);
    strobe(8'hFF);
    applyStimulus(2, 64'h5A_C3, 1'b1);
    waitDrain(50);
    checkOutput("junk_no_err", 32'(err_count), 32'(e_base));
    checkOutput("junk_ok", 32'(ok_count), 32'(o_base + 1));

    $display("[TB] inter-byte timeout");
    e_base = err_count;
    err_q.push_back(2'd2);
    strobe(8'hA5);
    strobe(8'h02);
    strobe(8'h44);
    t = strobe_cyc;
    n = 0;
    while (err_count == e_base && n < TO + 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("timeout_seen", 32'(err_count), 32'(e_base + 1));
    checkOutput("timeout_cycle", 32'(err_cyc), 32'(t + TO + 1));
    o_base = ok_count;
    applyStimulus(1, 64'h7E, 1'b1);
    waitDrain(50);
    checkOutput("after_timeout_ok", 32'(ok_count), 32'(o_base + 1));

    $display("[TB] byte arriving on the expiry cycle");
    e_base = err_count;
    o_base = ok_count;
    exp_q.push_back('{data: 8'h44, is_last: 1'b0});
    exp_q.push_back('{data: 8'h55, is_last: 1'b1});
    strobe(8'hA5);
    strobe(8'h02);
    strobe(8'h44);
    idle(TO - 1);
    strobe(8'h55);
`ifdef UART_FRAME_CHECKSUM_EN
    strobe(8'h65);
`endif
    waitDrain(50);
    checkOutput("collide_no_err", 32'(err_count), 32'(e_base));
    checkOutput("collide_ok", 32'(ok_count), 32'(o_base + 1));

    $display("[TB] stalled replay with overrun");
    byte_ready_i    = 1'b0;
    first_valid_cyc = -1;
    e_base          = err_count;
    applyStimulus(4, 64'h04_03_02_01, 1'b1);
    t = strobe_cyc;
    idle(2);
    err_q.push_back(2'd3);
    strobe(8'hA5);
    t2 = strobe_cyc;
    idle(3);
    checkOutput("stall_first_valid", 32'(first_valid_cyc), 32'(t + 2));
    checkOutput("stall_no_xfer", 32'(exp_q.size()), 32'd4);
    checkOutput("overrun_cycle", 32'(err_cyc), 32'(t2 + 1));
    byte_ready_i = 1'b1;
    waitDrain(50);
    checkOutput("overrun_count", 32'(err_count), 32'(e_base + 1));

    $display("[TB] reset during payload");
    strobe(8'hA5);
    strobe(8'h03);
    strobe(8'h11);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkResetState("rst_payload");
    reset  = 1'b0;
    o_base = ok_count;
    e_base = err_count;
    applyStimulus(3, 64'h66_55_44, 1'b1);
    waitDrain(50);
    checkOutput("rst_payload_ok", 32'(ok_count), 32'(o_base + 1));
    checkOutput("rst_payload_no_err", 32'(err_count), 32'(e_base));

    $display("[TB] reset during replay");
    byte_ready_i = 1'b0;
    applyStimulus(3, 64'h99_88_77, 1'b1);
    idle(3);
    checkOutput("pre_reset_valid", 32'(byte_valid_o), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkResetState("rst_send");
    reset = 1'b0;
    exp_q.delete();
    byte_ready_i = 1'b1;
    o_base = ok_count;
    applyStimulus(2, 64'hE2_E1, 1'b1);
    waitDrain(50);
    checkOutput("rst_send_ok", 32'(ok_count), 32'(o_base + 1));

    idle(5);
    checkOutput("err_q_empty", 32'(err_q.size()), 32'd0);
    checkOutput("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
